// File: rtl/exmem_stage_pkg.sv
// Shared EX/MEM pipeline definitions: default widths and the packed payload type.
package exmem_stage_pkg;

    localparam int EXMEM_DATA_W = 32;
    localparam int EXMEM_REG_W  = 5;

    // EX/MEM payload at the default widths; field order is the wire order.
    typedef struct packed {
        logic                    regwrite;
        logic                    memtoreg;
        logic                    memwrite;
        logic [EXMEM_DATA_W-1:0] busb;
        logic [EXMEM_DATA_W-1:0] alu;
        logic [EXMEM_REG_W-1:0]  rw;
    } exmem_t;

    localparam int EXMEM_W = $bits(exmem_t);

endpackage

// File: rtl/exmem_stage_pipe_slot.sv
// One pipeline slot: a valid flag plus a payload register.
// clr wins over load; clearing drops the valid flag but keeps the stale payload.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Slot state: reset zeroes everything, clear kills valid, load captures d.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, optional skid buffer,
// flush, and a forwarding tap for the EX hazard unit.
module exmem_stage
    import exmem_stage_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int REG_W  = EXMEM_REG_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic              in_memwrite,
    input  logic [DATA_W-1:0] in_busb,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rw,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwrite,
    output logic              out_memtoreg,
    output logic              out_memwrite,
    output logic [DATA_W-1:0] out_busb,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rw,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rw,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic              memwrite;
        logic [DATA_W-1:0] busb;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  rw;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t inPay;
    payload_t mainD;
    payload_t mainQ;
    logic     mainV;
    logic     mainLoad;
    logic     mainClr;
    logic     accept;
    logic     consume;

    assign inPay   = '{in_regwrite, in_memtoreg, in_memwrite, in_busb, in_alu, in_rw};
    assign accept  = in_valid & in_ready;
    assign consume = mainV & out_ready;

    pipe_slot #(.W(PW)) mainSlot (
        .clk   (clk),
        .rst   (rst),
        .load  (mainLoad),
        .clr   (mainClr),
        .d     (mainD),
        .valid (mainV),
        .q     (mainQ)
    );

    generate
        if (SKID != 0) begin : gSkid
            payload_t skidQ;
            logic     skidV;
            logic     skidLoad;
            logic     skidClr;

            pipe_slot #(.W(PW)) skidSlot (
                .clk   (clk),
                .rst   (rst),
                .load  (skidLoad),
                .clr   (skidClr),
                .d     (inPay),
                .valid (skidV),
                .q     (skidQ)
            );

            // Ready depends only on the skid flop, so out_ready never reaches in_ready.
            assign in_ready = ~skidV;

            // Main refills from skid first (oldest), else from EX; overflow parks in skid.
            always_comb begin
                mainD    = skidV ? skidQ : inPay;
                mainLoad = ~flush & ((consume & (skidV | accept)) | (~mainV & accept));
                mainClr  = flush | (consume & ~skidV & ~accept);
                skidLoad = ~flush & accept & mainV & ~consume;
                skidClr  = flush | (consume & skidV);
            end
        end else begin : gNoSkid
            // Single register: free this cycle if empty or being drained.
            assign in_ready = out_ready | ~mainV;

            // Load on every accept; drop valid when drained with nothing behind it.
            always_comb begin
                mainD    = inPay;
                mainLoad = ~flush & accept;
                mainClr  = flush | (consume & ~accept);
            end
        end
    endgenerate

    // Write enables are gated by valid so bubbles can never write.
    assign out_valid    = mainV;
    assign out_regwrite = mainQ.regwrite & mainV;
    assign out_memtoreg = mainQ.memtoreg;
    assign out_memwrite = mainQ.memwrite & mainV;
    assign out_busb     = mainQ.busb;
    assign out_alu      = mainQ.alu;
    assign out_rw       = mainQ.rw;

    // r0 is hardwired zero, so it is never a forwarding source.
    assign fwd_valid = mainV & mainQ.regwrite & (mainQ.rw != '0);
    assign fwd_rw    = mainQ.rw;
    assign fwd_data  = mainQ.alu;

endmodule

// File: doc/exmem_stage.md
EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the ALU result and store-data fields.
REQ-002 The block SHALL have parameter REG_W, default 5, width of the destination-register field.
REQ-003 The block SHALL have parameter SKID, default 1: 1 = registered in_ready with one-entry skid buffer; 0 = single register, combinational in_ready.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  EX stage presents a valid instruction.
REQ-007 in_ready  out  1  stage accepts EX payload this cycle.
REQ-008 in_regwrite, in_memtoreg, in_memwrite  in  1 each  EX control bits.
REQ-009 in_busb  in  DATA_W  store data; in_alu  in  DATA_W  ALU result; in_rw  in  REG_W  destination register.
REQ-010 flush  in  1  squash all held and incoming instructions.
REQ-011 out_valid  out  1  MEM-side payload valid; out_ready  in  1  MEM stage consumes it.
REQ-012 out_regwrite, out_memtoreg, out_memwrite  out  1 each; out_busb, out_alu  out  DATA_W; out_rw  out  REG_W.
REQ-013 fwd_valid  out  1, fwd_rw  out  REG_W, fwd_data  out  DATA_W  forwarding tap for the EX hazard unit.

Function
REQ-014 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-015 Latency SHALL be exactly one cycle from accept into an empty stage to out_valid high.
REQ-016 Payload SHALL be held unchanged on outputs while out_valid & ~out_ready (stall).
REQ-017 SKID=0: in_ready = out_ready | ~out_valid (combinational); main register loads on accept.
REQ-018 SKID=1: in_ready = ~skid_valid, driven from a flop; no combinational path from out_ready to in_ready.
REQ-019 SKID=1, accept while main full and not consumed: payload SHALL go to skid; skid_valid set.
REQ-020 SKID=1, consume while skid full: main SHALL load skid contents next cycle; skid_valid cleared; order preserved.
REQ-021 SKID=1, simultaneous accept and consume with skid empty: main SHALL load new payload, skid untouched.
REQ-022 No instruction SHALL be dropped, duplicated or reordered except by flush.
REQ-023 out_regwrite and out_memwrite SHALL be stored bit AND out_valid; bubbles never write.
REQ-024 fwd_valid = out_valid & out_regwrite & (out_rw != 0); fwd_rw = out_rw; fwd_data = out_alu.
REQ-025 flush SHALL clear main and skid valid next cycle; a same-cycle accept is discarded; flush beats every other event.
REQ-026 Payload fields SHALL only load on accept or skid transfer; invalid entries retain stale payload except after reset.

Reset
REQ-027 On rst high at a clock edge: out_valid=0, skid_valid=0, all stored control bits=0, out_busb=out_alu=0, out_rw=0.
REQ-028 After reset: in_ready=1, fwd_valid=0; rst SHALL override flush and accept in the same cycle.
REQ-029 Reset asserted mid-stall SHALL discard both entries; no output write-enable high in the following cycle.

Structure
REQ-030 Shared pipeline package SHALL hold a packed EX/MEM payload type (three control bits, busb, alu, rw) parameterised by DATA_W/REG_W defaults, and the default width constants.
REQ-031 One sub-module, pipe_slot (valid flag plus payload register with load/clear), SHALL be instantiated for main and, when SKID=1, skid.

Verification
REQ-032 Reset then accept alu=0x0000_0010, rw=3, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_alu=0x10, fwd_valid=1, fwd_rw=3.
REQ-033 SKID=1, out_ready=0, push A (alu=0xA) then B (alu=0xB) -> in_ready=0 after B; out_ready=1 -> A then B out on consecutive cycles, in_ready=1 again.
REQ-034 Stage full with memwrite=1, assert flush with in_valid=1 -> next cycle out_valid=0, out_memwrite=0, incoming payload absent in all later outputs.
REQ-035 Accept rw=0, regwrite=1 -> out_valid=1, fwd_valid=0.
REQ-036 SKID=0, stage full, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> new payload replaces old next cycle, no gap.
REQ-037 Both skid entries full, rst=1 one cycle -> out_valid=0, all outputs zero, in_ready=1 next cycle.
